// File: rtl/uart_rx_pkg.sv
// Shared UART types and helpers: receiver state encoding, data width and
// the baud divider calculation used by the rx (and later tx) blocks.
package lib_uart;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} UART_RX_STATE;

  localparam int UART_DATA_BITS = 8;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_bit_sync.sv
// Two-flop synchroniser for a single asynchronous bit, with a selectable
// reset value so idle-high lines do not glitch low coming out of reset.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver feeding the cpu: holds each byte with a level flag until
// the cpu acknowledges it, and reports overrun and framing errors as sticky bits.
module uart_rx
  import lib_uart::*;
#(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       irr,
  input  logic       ack,
  output logic       overrun,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  UART_RX_STATE state, state_next;
  logic [CNT_W-1:0]          cnt, cnt_next;
  logic [2:0]                bitidx, bitidx_next;
  logic [UART_DATA_BITS-1:0] shreg, shreg_next;
  logic rx_s, rx_s_prev;
  logic ack_q, ack_rise;
  logic byte_done, stop_bad;

  bit_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign ack_rise = ack & ~ack_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bitidx    <= '0;
      shreg     <= '0;
      rx_s_prev <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bitidx    <= bitidx_next;
      shreg     <= shreg_next;
      rx_s_prev <= rx_s;
      ack_q     <= ack;
    end
  end

  // Start is re-checked at mid-bit so short glitches fall back to IDLE;
  // data and stop bits are then sampled one full bit period apart.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    bitidx_next = bitidx;
    shreg_next  = shreg;
    byte_done   = 1'b0;
    stop_bad    = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (rx_s_prev && !rx_s) state_next = START;
      end
      START: begin
        if (cnt == CNT_W'(HALF_BIT - 1)) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next  = DATA;
            bitidx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_next    = '0;
          shreg_next  = {rx_s, shreg[UART_DATA_BITS-1:1]};
          bitidx_next = bitidx + 3'd1;
          if (bitidx == 3'd7) state_next = STOP;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_next   = '0;
          state_next = IDLE;
          byte_done  = rx_s;
          stop_bad   = ~rx_s;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // An ack edge landing on the delivery cycle frees the holding register,
  // so the new byte replaces the old one instead of counting as an overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data   <= '0;
      irr       <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (byte_done) begin
        if (!irr || ack_rise) begin
          rx_data <= shreg;
          irr     <= 1'b1;
          if (ack_rise) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
          end
        end else begin
          overrun <= 1'b1;
        end
      end else if (ack_rise) begin
        irr       <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (stop_bad) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: frames are driven
// bit by bit and every output is compared against hand-derived values.
module tb_uart_rx;
  import lib_uart::*;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] rx_data;
  logic       irr, overrun, frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  uart_rx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .irr       (irr),
    .ack       (ack),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame, driven at negedges. reset_at / ack_at (bit-time offsets in
  // clocks, -1 for none) inject a reset pulse or an ack rise mid-frame.
  // lat reports the clock count from the start edge to the irr rise.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit,
                               input int reset_at, input int ack_at,
                               output int lat_o);
    logic prev_irr;
    int   slot;
    lat_o    = -1;
    prev_irr = irr;
    for (int m = 0; m < 10 * CPB; m++) begin
      @(negedge clk);
      if (lat_o < 0 && irr && !prev_irr) lat_o = m;
      prev_irr = irr;
      slot = m / CPB;
      if (slot == 0)      rx = 1'b0;
      else if (slot == 9) rx = stop_bit;
      else                rx = b[slot-1];
      reset = (m == reset_at);
      if (m == ack_at)     ack = 1'b1;
      if (m == ack_at + 3) ack = 1'b0;
    end
    for (int m = 10 * CPB; m < 10 * CPB + 4; m++) begin
      @(negedge clk);
      if (lat_o < 0 && irr && !prev_irr) lat_o = m;
      prev_irr = irr;
      rx    = 1'b1;
      reset = 1'b0;
    end
  endtask

  task automatic ackPulse();
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
  endtask

  initial begin
    $display("[TB] uart_rx directed test start");
    idle(3);
    reset = 1'b0;
    idle(2);
    checkOutput("reset_irr",     irr,       1'b0);
    checkOutput("reset_data",    rx_data,   8'h00);
    checkOutput("reset_overrun", overrun,   1'b0);
    checkOutput("reset_ferr",    frame_err, 1'b0);

    // Plain byte, no ack
    applyStimulus(8'hA5, 1'b1, -1, -1, lat);
    checkOutput("a5_latency_ok", (lat >= 95 && lat <= 99), 1'b1);
    checkOutput("a5_data",    rx_data,   8'hA5);
    checkOutput("a5_irr",     irr,       1'b1);
    checkOutput("a5_overrun", overrun,   1'b0);
    checkOutput("a5_ferr",    frame_err, 1'b0);

    // Held-high ack only consumes once
    @(negedge clk) ack = 1'b1;
    @(negedge clk);
    checkOutput("ack_clears_irr", irr, 1'b0);
    applyStimulus(8'h3C, 1'b1, -1, -1, lat);
    idle(20);
    checkOutput("held_ack_irr",  irr,     1'b1);
    checkOutput("held_ack_data", rx_data, 8'h3C);
    ack = 1'b0;

    // Overrun: second byte dropped
    ackPulse();
    @(negedge clk);
    checkOutput("pre_ovr_irr", irr, 1'b0);
    applyStimulus(8'h11, 1'b1, -1, -1, lat);
    applyStimulus(8'h22, 1'b1, -1, -1, lat);
    checkOutput("ovr_data",    rx_data, 8'h11);
    checkOutput("ovr_irr",     irr,     1'b1);
    checkOutput("ovr_overrun", overrun, 1'b1);
    @(negedge clk) ack = 1'b1;
    @(negedge clk);
    checkOutput("ovr_ack_irr",     irr,     1'b0);
    checkOutput("ovr_ack_overrun", overrun, 1'b0);
    checkOutput("ovr_ack_data",    rx_data, 8'h11);
    ack = 1'b0;

    // Framing error then recovery
    applyStimulus(8'h55, 1'b0, -1, -1, lat);
    idle(5);
    checkOutput("fe_irr",  irr,       1'b0);
    checkOutput("fe_ferr", frame_err, 1'b1);
    checkOutput("fe_data", rx_data,   8'h11);
    applyStimulus(8'h0F, 1'b1, -1, -1, lat);
    checkOutput("fe_next_data", rx_data,   8'h0F);
    checkOutput("fe_next_irr",  irr,       1'b1);
    checkOutput("fe_sticky",    frame_err, 1'b1);
    ackPulse();
    @(negedge clk);
    checkOutput("fe_ack_ferr", frame_err, 1'b0);
    checkOutput("fe_ack_irr",  irr,       1'b0);

    // Short glitch is rejected
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(20);
    checkOutput("glitch_state",   dut.state, IDLE);
    checkOutput("glitch_irr",     irr,       1'b0);
    checkOutput("glitch_ferr",    frame_err, 1'b0);
    checkOutput("glitch_overrun", overrun,   1'b0);
    checkOutput("glitch_data",    rx_data,   8'h0F);

    // Reset during bit 4 of 0xFF
    applyStimulus(8'hFF, 1'b1, 55, -1, lat);
    idle(5);
    checkOutput("rst_mid_irr",  irr,       1'b0);
    checkOutput("rst_mid_data", rx_data,   8'h00);
    checkOutput("rst_mid_ovr",  overrun,   1'b0);
    checkOutput("rst_mid_ferr", frame_err, 1'b0);
    applyStimulus(8'h81, 1'b1, -1, -1, lat);
    checkOutput("post_rst_data", rx_data, 8'h81);
    checkOutput("post_rst_irr",  irr,     1'b1);

    // Ack rise coincident with delivery replaces the held byte
    applyStimulus(8'h5A, 1'b1, -1, 97, lat);
    checkOutput("coinc_data",    rx_data, 8'h5A);
    checkOutput("coinc_irr",     irr,     1'b1);
    checkOutput("coinc_overrun", overrun, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
